// File: rtl/rollover_monitor.sv
// Measures the cycle interval between consecutive counter rollover events and
// queues {dir, sat, interval} records in a small FIFO behind a valid/ready stream.
module rollover_monitor #(
  parameter int unsigned IW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rollover,
  input  logic                     down,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IW-1:0]            out_interval,
  output logic                     out_dir,
  output logic                     out_sat,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [IW-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic          dir;
    logic          sat;
    logic [IW-1:0] interval;
  } rec_t;

  typedef enum logic {IDLE, TIMING} state_t;

  state_t         state;
  logic           rollover_q;
  logic [IW-1:0]  cnt;
  rec_t           mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [LW-1:0]  level;

  logic evt_c;
  logic push_c;
  logic pop_c;
  logic full_c;
  logic wr_en_c;
  rec_t rec_c;

  // Rising edge of rollover only; a held-high flag is one event.
  assign evt_c   = rollover & ~rollover_q;
  assign push_c  = evt_c && (state == TIMING);
  assign pop_c   = out_valid && out_ready;
  assign full_c  = (level == LW'(DEPTH));
  assign wr_en_c = push_c && (!full_c || pop_c);
  assign rec_c   = '{dir: down, sat: (cnt == CNT_MAX), interval: cnt};

  assign out_valid    = (level != '0);
  assign out_interval = mem[rd_ptr].interval;
  assign out_dir      = mem[rd_ptr].dir;
  assign out_sat      = mem[rd_ptr].sat;
  assign fifo_level   = level;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rollover_q <= 1'b0;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rollover_q <= rollover;
      if (clear) begin
        // Flush everything except the edge detector, so a held flag stays quiet.
        state    <= IDLE;
        cnt      <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        overflow <= 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (evt_c) begin
              state <= TIMING;
              cnt   <= IW'(1);
            end
          end
          TIMING: begin
            if (evt_c) begin
              cnt <= IW'(1);
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + IW'(1);
            end
          end
          default: state <= IDLE;
        endcase

        if (wr_en_c) begin
          mem[wr_ptr] <= rec_c;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (push_c && full_c && !pop_c) overflow <= 1'b1;
        if (pop_c) rd_ptr <= rd_ptr + PW'(1);
        level <= level + LW'(wr_en_c) - LW'(pop_c);
      end
    end
  end

endmodule

// File: tb/tb_rollover_monitor.sv
// Directed bench for rollover_monitor: event table plus hand-written
// sequences for drain order, full-with-pop, clear/rst flushes and saturation.
module tb_rollover_monitor;

  logic       clk = 1'b0;
  logic       rst, rollover, down, clear, out_ready;
  logic       out_valid, out_dir, out_sat, overflow;
  logic [7:0] out_interval;
  logic [2:0] fifo_level;
  logic       o4_valid, o4_dir, o4_sat, o4_overflow;
  logic [3:0] o4_interval;
  logic [2:0] o4_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rollover_monitor #(.IW(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .rollover(rollover), .down(down), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_interval(out_interval),
    .out_dir(out_dir), .out_sat(out_sat), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  rollover_monitor #(.IW(4), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .rollover(rollover), .down(down), .clear(clear),
    .out_valid(o4_valid), .out_ready(out_ready), .out_interval(o4_interval),
    .out_dir(o4_dir), .out_sat(o4_sat), .fifo_level(o4_level),
    .overflow(o4_overflow)
  );

  typedef struct {
    int   gap;
    logic dn;
    logic rdy;
    int   lvl;
    logic vld;
    int   intv;
    logic dir;
    logic sat;
    logic ovf;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // gap-1 quiet cycles then a one-cycle rollover pulse; returns just after the event edge.
  task automatic run_gap(input int gap);
    rollover = 1'b0;
    for (int i = 0; i < gap - 1; i++) tick();
    rollover = 1'b1;
    tick();
    rollover = 1'b0;
  endtask

  task automatic chk_state(input string nm, input int lvl, input int vld, input int ovf);
    chk({nm, ".level"},    int'(fifo_level), lvl);
    chk({nm, ".valid"},    int'(out_valid),  vld);
    chk({nm, ".overflow"}, int'(overflow),   ovf);
  endtask

  task automatic chk_head(input string nm, input int intv, input int dir, input int sat);
    chk({nm, ".interval"}, int'(out_interval), intv);
    chk({nm, ".dir"},      int'(out_dir),      dir);
    chk({nm, ".sat"},      int'(out_sat),      sat);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // gap, down, ready | level, valid, interval, dir, sat, overflow
    tbl[0] = '{5,  1'b0, 1'b1, 0, 1'b0, 0,  1'b0, 1'b0, 1'b0};
    tbl[1] = '{16, 1'b0, 1'b1, 1, 1'b1, 16, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{16, 1'b0, 1'b1, 1, 1'b1, 16, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{16, 1'b1, 1'b1, 1, 1'b1, 16, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{7,  1'b1, 1'b1, 1, 1'b1, 7,  1'b1, 1'b0, 1'b0};
    tbl[5] = '{10, 1'b0, 1'b0, 2, 1'b1, 7,  1'b1, 1'b0, 1'b0};
    tbl[6] = '{11, 1'b0, 1'b0, 3, 1'b1, 7,  1'b1, 1'b0, 1'b0};
    tbl[7] = '{12, 1'b0, 1'b0, 4, 1'b1, 7,  1'b1, 1'b0, 1'b0};
    tbl[8] = '{13, 1'b0, 1'b0, 4, 1'b1, 7,  1'b1, 1'b0, 1'b1};

    rst = 1'b1; rollover = 1'b0; down = 1'b0; clear = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_state("reset", 0, 0, 0);
    chk_head("reset", 0, 0, 0);

    for (int k = 0; k < 9; k++) begin
      down      = tbl[k].dn;
      out_ready = tbl[k].rdy;
      run_gap(tbl[k].gap);
      chk_state($sformatf("vec%0d", k), tbl[k].lvl, int'(tbl[k].vld), int'(tbl[k].ovf));
      if (tbl[k].vld)
        chk_head($sformatf("vec%0d", k), tbl[k].intv, int'(tbl[k].dir), int'(tbl[k].sat));
    end

    // Drain: retained records come out in order, the dropped one never appears.
    out_ready = 1'b1;
    tick(); chk_head("drain1", 10, 0, 0); chk_state("drain1", 3, 1, 1);
    tick(); chk_head("drain2", 11, 0, 0);
    tick(); chk_head("drain3", 12, 0, 0);
    tick(); chk_state("drain_empty", 0, 0, 1);

    // Clear empties and drops overflow; next event is treated as the first.
    do_clear();
    chk_state("clear", 0, 0, 0);
    chk("clear.interval", int'(out_interval), 0);
    run_gap(5);
    chk_state("idle_after_clear", 0, 0, 0);

    // Fill to full, then push and pop on the same edge.
    out_ready = 1'b0;
    run_gap(3); run_gap(4); run_gap(5); run_gap(6);
    chk_state("full", 4, 1, 0);
    chk_head("full", 3, 0, 0);
    for (int i = 0; i < 7; i++) tick();
    rollover = 1'b1; out_ready = 1'b1;
    tick();
    rollover = 1'b0;
    chk_state("full_pop", 4, 1, 0);
    chk_head("full_pop", 4, 0, 0);
    tick(); chk("fp_drain1", int'(out_interval), 5);
    tick(); chk("fp_drain2", int'(out_interval), 6);
    tick(); chk("fp_drain3", int'(out_interval), 8);
    tick(); chk_state("fp_empty", 0, 0, 0);

    // Clear on an event edge with three records queued; held rollover stays quiet.
    out_ready = 1'b0;
    run_gap(3); run_gap(3); run_gap(3);
    chk("pre_clear.level", int'(fifo_level), 3);
    tick(); tick();
    rollover = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_state("clear_evt", 0, 0, 0);
    tick(); tick(); tick();
    chk_state("clear_held", 0, 0, 0);
    run_gap(4);
    chk_state("clear_first", 0, 0, 0);
    run_gap(4);
    chk_state("clear_second", 1, 1, 0);
    chk_head("clear_second", 4, 0, 0);

    // Reset on an event edge with three records queued.
    run_gap(3); run_gap(3);
    chk("pre_rst.level", int'(fifo_level), 3);
    tick();
    rollover = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; rollover = 1'b0;
    chk_state("rst_evt", 0, 0, 0);
    chk_head("rst_evt", 0, 0, 0);
    run_gap(4);
    chk_state("rst_first", 0, 0, 0);
    down = 1'b1;
    run_gap(6);
    chk_state("rst_second", 1, 1, 0);
    chk_head("rst_second", 6, 1, 0);

    // Saturation boundaries on the 4-bit instance.
    out_ready = 1'b1;
    down = 1'b0;
    do_clear();
    run_gap(3);
    chk("sat_first.level4", int'(o4_level), 0);
    run_gap(20);
    chk("sat20.interval4", int'(o4_interval), 15);
    chk("sat20.sat4", int'(o4_sat), 1);
    chk("sat20.interval8", int'(out_interval), 20);
    chk("sat20.sat8", int'(out_sat), 0);
    run_gap(15);
    chk("sat15.interval4", int'(o4_interval), 15);
    chk("sat15.sat4", int'(o4_sat), 1);
    run_gap(14);
    chk("sat14.interval4", int'(o4_interval), 14);
    chk("sat14.sat4", int'(o4_sat), 0);
    chk("sat14.valid4", int'(o4_valid), 1);
    chk("sat14.overflow4", int'(o4_overflow), 0);
    chk("sat14.dir4", int'(o4_dir), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
